// File: rtl/canny_hysteresis_stream_if.sv
// rtl/canny_hysteresis_stream_if.sv - stream bundle between the NMS stage, the hysteresis stage and the TX packer
// Purpose: groups the magnitude input stream and the binary edge output stream.
// Signals: frame_start - one-cycle frame resync pulse
//          mag_de      - input pixel valid
//          mag_data    - 8-bit unsigned gradient magnitude
//          canny_de    - output pixel valid (one-cycle pulse per pixel)
//          canny_data  - 0xFF edge / 0x00 background
//          busy        - end-of-frame flush in progress
// Modports: master drives the magnitude side, slave is the hysteresis stage.
interface canny_hysteresis_stream_if;
   logic       frame_start;
   logic       mag_de;
   logic [7:0] mag_data;
   logic       canny_de;
   logic [7:0] canny_data;
   logic       busy;

   modport master (
      output frame_start, mag_de, mag_data,
      input  canny_de, canny_data, busy
   );

   modport slave (
      input  frame_start, mag_de, mag_data,
      output canny_de, canny_data, busy
   );
endinterface

// File: rtl/canny_hysteresis_stream.sv
// rtl/canny_hysteresis_stream.sv - double-threshold 3x3 hysteresis on a gradient-magnitude stream
// Purpose: classifies each magnitude beat as none/weak/strong, builds a 3x3 class
//          window from two line buffers and emits 0xFF/0x00 per pixel in raster
//          order, flushing the last IMG_W+1 (border) pixels after the frame ends.
// Ports:   clk   - system clock
//          reset - synchronous active-high reset
//          s     - stream bundle (slave): frame_start, mag_de, mag_data in;
//                  canny_de, canny_data, busy out
module canny_hysteresis_stream #(
   parameter int IMG_W   = 176,
   parameter int IMG_H   = 240,
   parameter int TH_HIGH = 100,
   parameter int TH_LOW  = 40
) (
   input  logic                     clk,
   input  logic                     reset,
   canny_hysteresis_stream_if.slave s
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int FW = $clog2(IMG_W + 1);
   localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_W);
   localparam logic [7:0]    TH_HIGH_B  = 8'(TH_HIGH);
   localparam logic [7:0]    TH_LOW_B   = 8'(TH_LOW);

   typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d, c_in;
   logic [RW-1:0] row_q, row_d, r_in;
   logic [FW-1:0] flush_cnt_q, flush_cnt_d;
   logic          beat, last_beat, busy, flush_issue;
   logic [1:0]    cls;
   logic [1:0]    lb_top_q [IMG_W];   // classes of row r_in-2
   logic [1:0]    lb_mid_q [IMG_W];   // classes of row r_in-1
   logic [5:0]    win_q [3];          // window columns oldest..newest, each {top,mid,bot}
   logic          v1_q, v1_d, int1_q, int1_d;
   logic          de_q;
   logic [7:0]    data_q;
   logic [1:0]    centre;
   logic          any_strong, edge_px;

   // A frame_start beat is always pixel (0,0), even when it arrives mid-flush.
   assign beat      = s.mag_de && (state_q == S_RUN || s.frame_start);
   assign c_in      = s.frame_start ? '0 : col_q;
   assign r_in      = s.frame_start ? '0 : row_q;
   assign last_beat = beat && (c_in == COL_LAST) && (r_in == ROW_LAST);

   always_comb begin
      if (s.mag_data >= TH_HIGH_B)     cls = 2'd2;
      else if (s.mag_data >= TH_LOW_B) cls = 2'd1;
      else                             cls = 2'd0;
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_RUN;
      else       state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN:   if (last_beat) state_d = S_FLUSH;
         S_FLUSH: if (s.frame_start || flush_cnt_q == FLUSH_LAST) state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy        = (state_q == S_FLUSH);
      flush_issue = (state_q == S_FLUSH) && !s.frame_start;
   end

   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      v1_d        = 1'b0;
      int1_d      = 1'b0;
      flush_cnt_d = (state_q == S_FLUSH && state_d == S_FLUSH) ? flush_cnt_q + FW'(1) : '0;
      if (flush_issue) v1_d = 1'b1;
      if (s.frame_start) begin
         col_d = '0;
         row_d = '0;
      end
      if (beat) begin
         // Output index k-(IMG_W+1) exists once k >= IMG_W+1; its centre is
         // (r_in-1, c_in-1), which is interior only for r_in >= 2 and c_in >= 2.
         v1_d   = (r_in != '0) && !(r_in == RW'(1) && c_in == '0);
         int1_d = (r_in > RW'(1)) && (c_in > CW'(1));
         if (c_in == COL_LAST) begin
            col_d = '0;
            row_d = (r_in == ROW_LAST) ? '0 : r_in + RW'(1);
         end else begin
            col_d = c_in + CW'(1);
            row_d = r_in;
         end
      end
   end

   always_comb begin
      centre     = win_q[1][3:2];
      any_strong = 1'b0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            if (win_q[i][2*j +: 2] == 2'd2) any_strong = 1'b1;
         end
      end
      edge_px = int1_q && (centre == 2'd2 || (centre == 2'd1 && any_strong));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_q       <= '0;
         row_q       <= '0;
         flush_cnt_q <= '0;
         v1_q        <= 1'b0;
         int1_q      <= 1'b0;
         de_q        <= 1'b0;
         data_q      <= 8'h00;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         flush_cnt_q <= flush_cnt_d;
         v1_q        <= v1_d;
         int1_q      <= int1_d;
         de_q        <= v1_q;
         data_q      <= edge_px ? 8'hFF : 8'h00;
      end
   end

   // Line buffers and window hold no reset: rows that could be stale only
   // ever feed border pixels, which are forced to background.
   always_ff @(posedge clk) begin
      if (beat) begin
         lb_top_q[c_in] <= lb_mid_q[c_in];
         lb_mid_q[c_in] <= cls;
         win_q[0]       <= win_q[1];
         win_q[1]       <= win_q[2];
         win_q[2]       <= {lb_top_q[c_in], lb_mid_q[c_in], cls};
      end
   end

   assign s.canny_de   = de_q;
   assign s.canny_data = data_q;
   assign s.busy       = busy;
endmodule

// File: tb/tb_canny_hysteresis_stream.sv
// tb/tb_canny_hysteresis_stream.sv - scoreboard bench for canny_hysteresis_stream on an 8x6 frame
module tb_canny_hysteresis_stream;
   localparam int W = 8;
   localparam int H = 6;
   localparam int N = W * H;

   typedef struct {
      logic [7:0] d;
      int         c;
   } exp_t;

   logic       clk;
   logic       reset;
   int         cyc = 0;
   int         vecs = 0;
   int         fails = 0;
   bit         quiet;
   bit         exp_busy;
   bit         done;
   exp_t       q[$];
   logic [7:0] img [N];
   logic [7:0] expv [N];

   canny_hysteresis_stream_if bus ();

   canny_hysteresis_stream #(
      .IMG_W(W), .IMG_H(H), .TH_HIGH(100), .TH_LOW(40)
   ) dut (
      .clk(clk),
      .reset(reset),
      .s(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic drive(input bit de, input logic [7:0] d, input bit fs, output int e);
      bus.mag_de      = de;
      bus.mag_data    = d;
      bus.frame_start = fs;
      @(posedge clk);
      e = cyc;
      #1;
      bus.mag_de      = 1'b0;
      bus.mag_data    = 8'h00;
      bus.frame_start = 1'b0;
   endtask

   task automatic idle(input int n);
      int e;
      repeat (n) drive(1'b0, 8'h00, 1'b0, e);
   endtask

   task automatic push_exp(input logic [7:0] d, input int c);
      exp_t x;
      x.d = d;
      x.c = c;
      q.push_back(x);
   endtask

   task automatic clear_frame();
      for (int i = 0; i < N; i++) begin
         img[i]  = 8'h00;
         expv[i] = 8'h00;
      end
   endtask

   task automatic set_px(input int i, input logic [7:0] v);
      img[i] = v;
   endtask

   task automatic set_edge(input int i);
      expv[i] = 8'hFF;
   endtask

   // flush_mode: 0 idle flush, 1 beats offered during flush, 2 reset two cycles into flush
   task automatic run_frame(input int gap_max, input int nbeats, input bit fs_first, input int flush_mode);
      int e, e2;
      e = 0;
      for (int k = 0; k < nbeats; k++) begin
         if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
         drive(1'b1, img[k], fs_first && (k == 0), e);
         if (k >= W + 1) push_exp(expv[k - W - 1], e + 2);
      end
      if (nbeats == N) begin
         exp_busy = 1'b1;
         if (flush_mode == 2) begin
            push_exp(expv[N - W - 1], e + 3);
            idle(2);
            reset = 1'b1;
            idle(1);
            reset = 1'b0;
            exp_busy = 1'b0;
         end else begin
            for (int i = 0; i <= W; i++) begin
               push_exp(expv[N - W - 1 + i], e + 3 + i);
               drive(flush_mode == 1, 8'd200, 1'b0, e2);
            end
            exp_busy = 1'b0;
         end
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t x;
      if (done) begin
         vecs++;
         if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d outputs still pending, required 0", q.size());
         end
         $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
         $finish;
      end else begin
         vecs++;
         if (bus.busy !== exp_busy) begin
            fails++;
            $display("FAIL busy @%0d: got %b, required %b", cyc, bus.busy, exp_busy);
         end
         if (quiet) begin
            vecs++;
            if (bus.canny_de !== 1'b0 || bus.canny_data !== 8'h00) begin
               fails++;
               $display("FAIL reset_state @%0d: de=%b data=%h, required de=0 data=00",
                        cyc, bus.canny_de, bus.canny_data);
            end
         end else if (bus.canny_de === 1'b1) begin
            vecs++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_out @%0d: data=%h, required no output", cyc, bus.canny_data);
            end else begin
               x = q.pop_front();
               if (bus.canny_data !== x.d || cyc != x.c) begin
                  fails++;
                  $display("FAIL out: got data=%h at %0d, required data=%h at %0d",
                           bus.canny_data, cyc, x.d, x.c);
               end
            end
         end else if (bus.canny_de !== 1'b0) begin
            vecs++;
            fails++;
            $display("FAIL canny_de @%0d: got %b, required 0 or 1", cyc, bus.canny_de);
         end
      end
   end

   initial begin : main
      int e;
      bus.mag_de      = 1'b0;
      bus.mag_data    = 8'h00;
      bus.frame_start = 1'b0;
      reset    = 1'b1;
      quiet    = 1'b1;
      exp_busy = 1'b0;
      done     = 1'b0;
      idle(3);
      reset = 1'b0;
      idle(2);
      quiet = 1'b0;

      // all-zero frame
      clear_frame(); run_frame(0, N, 1'b1, 0);
      // single strong interior pixel
      clear_frame(); set_px(19, 200); set_edge(19); run_frame(0, N, 1'b1, 0);
      // strong pixels on the border only
      clear_frame(); set_px(0, 200); set_px(31, 200); run_frame(0, N, 1'b0, 0);
      // weak with diagonal strong neighbour
      clear_frame(); set_px(19, 50); set_px(28, 120); set_edge(19); set_edge(28); run_frame(0, N, 1'b1, 0);
      // weak alone
      clear_frame(); set_px(19, 50); run_frame(0, N, 1'b1, 0);
      // weak with distant strong
      clear_frame(); set_px(19, 50); set_px(37, 120); set_edge(37); run_frame(0, N, 1'b1, 0);
      // threshold edges
      clear_frame(); set_px(18, 100); set_edge(18); run_frame(0, N, 1'b1, 0);
      clear_frame(); set_px(18, 99); run_frame(0, N, 1'b1, 0);
      clear_frame(); set_px(18, 99); set_px(19, 150); set_edge(18); set_edge(19); run_frame(0, N, 1'b1, 0);
      clear_frame(); set_px(18, 40); set_px(19, 150); set_edge(18); set_edge(19); run_frame(0, N, 1'b1, 0);
      clear_frame(); set_px(18, 39); set_px(19, 150); set_edge(19); run_frame(0, N, 1'b1, 0);
      // random input gaps
      clear_frame(); set_px(19, 50); set_px(28, 120); set_edge(19); set_edge(28); run_frame(2, N, 1'b1, 0);
      // frame_start on its own after beat 20, then a full frame
      clear_frame(); set_px(19, 200); set_edge(19); run_frame(0, 21, 1'b1, 0);
      drive(1'b0, 8'h00, 1'b1, e);
      clear_frame(); set_px(19, 50); set_px(28, 120); set_edge(19); set_edge(28); run_frame(0, N, 1'b0, 0);
      // partial frame, then frame_start coincident with the first beat
      clear_frame(); set_px(19, 200); set_edge(19); run_frame(1, 15, 1'b0, 0);
      clear_frame(); set_px(19, 50); set_px(37, 120); set_edge(37); run_frame(0, N, 1'b1, 0);
      // reset during flush, then a clean frame
      clear_frame(); set_px(19, 200); set_edge(19); run_frame(0, N, 1'b1, 2);
      run_frame(0, N, 1'b0, 0);
      // beats offered while busy, then a clean frame
      clear_frame(); set_px(19, 50); set_px(37, 120); set_edge(37); run_frame(0, N, 1'b1, 1);
      clear_frame(); set_px(19, 200); set_edge(19); run_frame(0, N, 1'b0, 0);

      idle(W + 4);
      done = 1'b1;
   end
endmodule
